// File: rtl/instr_cache_tag_array.sv
// -----------------------------------------------------------------------------
// instr_cache_tag_array
//
// Tag/valid array for a set-associative instruction cache with a one-cycle
// lookup pipeline, fill with victim selection, and a walking invalidate-all.
//
// Stage 0 reads the indexed set into a register. Stage 1 compares the
// registered tags against the TLB-translated address presented that cycle.
//
// Optional feature macro: ICACHE_TAG_ASID_EN
//   defined   : each way also stores an ASID; a match requires ASID equality
//   undefined : no ASID storage; i_asid and i_fill_asid are unused
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous active-high reset
//   i_req_valid    lookup request (stage 0)
//   i_vaddr        lookup virtual address, supplies the set index (stage 0)
//   i_asid         lookup ASID (stage 1)
//   i_paddr        translated address, supplies the compare tag (stage 1)
//   i_tlb_hit      translation valid (stage 1)
//   o_hit          stage-1 hit
//   o_miss         stage-1 miss
//   o_hit_way      one-hot hitting way
//   i_fill_valid   line install request
//   i_fill_vaddr   fill index source
//   i_fill_paddr   fill tag source
//   i_fill_asid    fill ASID
//   i_flush        invalidate-all request
//   o_ready        lookups and fills are accepted
//   o_flush_done   one-cycle pulse in the last cycle of a flush walk
// -----------------------------------------------------------------------------

`ifndef VADDR_WIDTH
`define VADDR_WIDTH 32
`endif
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef ASID_WIDTH
`define ASID_WIDTH 8
`endif

module instr_cache_tag_array #(
   parameter int unsigned SETS       = 64,
   parameter int unsigned WAYS       = 2,
   parameter int unsigned LINE_BYTES = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_req_valid,
   input  logic [`VADDR_WIDTH-1:0]  i_vaddr,
   input  logic [`ASID_WIDTH-1:0]   i_asid,
   input  logic [`PADDR_WIDTH-1:0]  i_paddr,
   input  logic                     i_tlb_hit,
   output logic                     o_hit,
   output logic                     o_miss,
   output logic [WAYS-1:0]          o_hit_way,
   input  logic                     i_fill_valid,
   input  logic [`VADDR_WIDTH-1:0]  i_fill_vaddr,
   input  logic [`PADDR_WIDTH-1:0]  i_fill_paddr,
   input  logic [`ASID_WIDTH-1:0]   i_fill_asid,
   input  logic                     i_flush,
   output logic                     o_ready,
   output logic                     o_flush_done
);

   localparam int unsigned OFF = $clog2(LINE_BYTES);
   localparam int unsigned IDX = $clog2(SETS);
   localparam int unsigned TAG = `PADDR_WIDTH - IDX - OFF;
   localparam int unsigned PW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // ---------------------------------------------------------------- storage
   logic [WAYS-1:0] valid_mem [SETS];
   logic [TAG-1:0]  tag_mem   [SETS][WAYS];
   logic [PW-1:0]   rr_ptr    [SETS];
`ifdef ICACHE_TAG_ASID_EN
   logic [`ASID_WIDTH-1:0] asid_mem [SETS][WAYS];
`endif

   // ---------------------------------------------------------------- control
   state_t          state;
   logic [IDX-1:0]  flush_cnt;
   logic            flush_done;

   logic            ready;
   logic            lookup_go;
   logic            fill_go;

   // A flush request closes the door in the same cycle, so a concurrent fill
   // or lookup is dropped.
   assign ready     = (state == IDLE) && !i_flush;
   assign lookup_go = i_req_valid && ready;
   assign fill_go   = i_fill_valid && ready;

   assign o_ready      = ready;
   assign o_flush_done = flush_done;

   // ---------------------------------------------------------- address fields
   logic [IDX-1:0] req_idx;
   logic [IDX-1:0] fill_idx;
   logic [TAG-1:0] look_tag;
   logic [TAG-1:0] fill_tag;

   assign req_idx  = i_vaddr[OFF+IDX-1:OFF];
   assign fill_idx = i_fill_vaddr[OFF+IDX-1:OFF];
   assign look_tag = i_paddr[`PADDR_WIDTH-1:OFF+IDX];
   assign fill_tag = i_fill_paddr[`PADDR_WIDTH-1:OFF+IDX];

   // Every input bit is consumed somewhere in at least one build; this keeps
   // the bits outside the index/tag fields from being flagged.
   logic unused_bits;
   assign unused_bits = ^{i_vaddr, i_paddr, i_fill_vaddr, i_fill_paddr,
                          i_asid, i_fill_asid};

   // ---------------------------------------------------------------- stage 1
   logic            s1_valid;
   logic [WAYS-1:0] s1_vbits;
   logic [TAG-1:0]  s1_tags [WAYS];
`ifdef ICACHE_TAG_ASID_EN
   logic [`ASID_WIDTH-1:0] s1_asids [WAYS];
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= lookup_go;
      end
   end

   // Reading here sees the array before any same-cycle fill lands.
   always_ff @(posedge i_clk) begin
      if (lookup_go) begin
         s1_vbits <= valid_mem[req_idx];
         for (int unsigned w = 0; w < WAYS; w++) begin
            s1_tags[w] <= tag_mem[req_idx][w];
`ifdef ICACHE_TAG_ASID_EN
            s1_asids[w] <= asid_mem[req_idx][w];
`endif
         end
      end
   end

   logic [WAYS-1:0] look_asid_ok;
   logic [WAYS-1:0] look_match;
   logic            look_any;

   always_comb begin
      look_asid_ok = '1;
`ifdef ICACHE_TAG_ASID_EN
      for (int unsigned w = 0; w < WAYS; w++) begin
         look_asid_ok[w] = (s1_asids[w] == i_asid);
      end
`endif
      look_match = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         look_match[w] = s1_vbits[w] && (s1_tags[w] == look_tag) && look_asid_ok[w];
      end
      look_any = |look_match;
   end

   assign o_hit     = s1_valid && i_tlb_hit && look_any;
   assign o_miss    = s1_valid && i_tlb_hit && !look_any;
   assign o_hit_way = s1_valid ? look_match : '0;

   // -------------------------------------------------------- victim selection
   // Priority: an existing matching way (rewrite in place), then the lowest
   // invalid way, then the set's round-robin pointer.
   logic [WAYS-1:0] fill_vbits;
   logic [WAYS-1:0] fill_match;
   logic [PW-1:0]   victim;
   logic            victim_found;
   logic            use_rr;
   logic [PW-1:0]   rr_next;

   always_comb begin
      fill_vbits   = valid_mem[fill_idx];
      fill_match   = '0;
      victim       = '0;
      victim_found = 1'b0;
      use_rr       = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         fill_match[w] = fill_vbits[w] && (tag_mem[fill_idx][w] == fill_tag)
`ifdef ICACHE_TAG_ASID_EN
                         && (asid_mem[fill_idx][w] == i_fill_asid)
`endif
                         ;
      end
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!victim_found && fill_match[w]) begin
            victim       = PW'(w);
            victim_found = 1'b1;
         end
      end
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!victim_found && !fill_vbits[w]) begin
            victim       = PW'(w);
            victim_found = 1'b1;
         end
      end
      if (!victim_found) begin
         victim = rr_ptr[fill_idx];
         use_rr = 1'b1;
      end
      rr_next = (rr_ptr[fill_idx] == PW'(WAYS - 1)) ? '0 : rr_ptr[fill_idx] + PW'(1);
   end

   // ------------------------------------------------- valid bits and pointers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_mem <= '{default: '0};
         rr_ptr    <= '{default: '0};
      end else if (state == FLUSH) begin
         valid_mem[flush_cnt] <= '0;
      end else if (fill_go) begin
         valid_mem[fill_idx][victim] <= 1'b1;
         if (use_rr) begin
            rr_ptr[fill_idx] <= rr_next;
         end
      end
   end

   // Tag (and ASID) storage carries no reset; valid bits qualify it.
   always_ff @(posedge i_clk) begin
      if (fill_go) begin
         tag_mem[fill_idx][victim] <= fill_tag;
`ifdef ICACHE_TAG_ASID_EN
         asid_mem[fill_idx][victim] <= i_fill_asid;
`endif
      end
   end

   // --------------------------------------------------------------- flush FSM
   // flush_done is registered one cycle early so it is high exactly while the
   // walk clears the last set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         flush_cnt  <= '0;
         flush_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               flush_done <= 1'b0;
               if (i_flush) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
               end
            end
            FLUSH: begin
               flush_cnt  <= flush_cnt + IDX'(1);
               flush_done <= (flush_cnt == IDX'(SETS - 2));
               if (flush_cnt == IDX'(SETS - 1)) begin
                  state <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               flush_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
